bus_out_arbiter: RTL and testbench

BUS_OUT_ARBITER -- requirements
Module: bus_out_arbiter

---
 rtl/bus_out_arbiter.sv | 124 ++++++++++++
 tb/tb_bus_out_arbiter.sv | 342 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bus_out_arbiter.sv
// Apple bus read-data arbiter: grants one card per phi0 cycle (lowest index wins),
// drives its data through phi0 and a short hold window, and aggregates card interrupts.
module bus_out_arbiter #(
  parameter int NUM_REQ             = 4,
  parameter int HOLD_CYCLES         = 2,
  parameter int BUS_DATA_OUT_ENABLE = 1,
  parameter int IRQ_OUT_ENABLE      = 1
) (
  input  logic                 clk_logic,
  input  logic                 device_reset_n,
  input  logic                 phi1_negedge,
  input  logic                 phi1_posedge,
  input  logic                 rw_n,
  input  logic [NUM_REQ-1:0]   req_i,
  input  logic [NUM_REQ*8-1:0] data_i,
  input  logic [NUM_REQ-1:0]   irq_n_i,
  input  logic [NUM_REQ-1:0]   irq_mask_i,
  output logic                 data_out_en_o,
  output logic [7:0]           data_out_o,
  output logic [NUM_REQ-1:0]   grant_o,
  output logic                 irq_n_o,
  output logic                 conflict_o,
  output logic [7:0]           conflict_count_o
);

  localparam int   IDX_W    = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam logic DRIVE_EN = (BUS_DATA_OUT_ENABLE != 0);
  localparam logic IRQ_EN   = (IRQ_OUT_ENABLE != 0);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_DRIVE, S_HOLD} state_t;

  state_t           state;
  logic [3:0]       hold_cnt;
  logic [IDX_W-1:0] gnt_idx;
  logic [IDX_W-1:0] low_idx;
  logic [3:0]       req_pop;
  logic [7:0]       low_data;
  logic [7:0]       gnt_data;
  logic             irq_all_n;

  always_comb begin
    low_idx = '0;
    req_pop = '0;
    // Scan downwards so the lowest set index is the last one written.
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      if (req_i[k]) low_idx = IDX_W'(k);
    end
    for (int k = 0; k < NUM_REQ; k++) begin
      req_pop = req_pop + {3'b000, req_i[k]};
    end
    low_data  = data_i[8*int'(low_idx) +: 8];
    gnt_data  = data_i[8*int'(gnt_idx) +: 8];
    irq_all_n = &(irq_n_i | ~irq_mask_i);
  end

  always_ff @(posedge clk_logic or negedge device_reset_n) begin
    if (!device_reset_n) begin
      state            <= S_IDLE;
      hold_cnt         <= '0;
      gnt_idx          <= '0;
      data_out_en_o    <= 1'b0;
      data_out_o       <= 8'h00;
      grant_o          <= '0;
      irq_n_o          <= 1'b1;
      conflict_o       <= 1'b0;
      conflict_count_o <= 8'h00;
    end else begin
      conflict_o <= 1'b0;
      irq_n_o    <= IRQ_EN ? irq_all_n : 1'b1;
      case (state)
        S_IDLE: begin
          if (phi1_negedge) state <= S_WAIT;
        end
        S_WAIT: begin
          if (rw_n && (req_i != '0)) begin
            state         <= S_DRIVE;
            gnt_idx       <= low_idx;
            grant_o       <= NUM_REQ'(1) << low_idx;
            data_out_o    <= low_data;
            data_out_en_o <= DRIVE_EN;
            if (req_pop > 4'd1) begin
              conflict_o <= 1'b1;
              if (conflict_count_o != 8'hFF) conflict_count_o <= conflict_count_o + 8'd1;
            end
          end else if (phi1_posedge && !phi1_negedge) begin
            state <= S_IDLE;
          end
        end
        S_DRIVE: begin
          if (!req_i[gnt_idx]) begin
            data_out_en_o <= 1'b0;
            data_out_o    <= 8'h00;
            grant_o       <= '0;
            state         <= phi1_negedge ? S_WAIT : S_IDLE;
          end else if (phi1_posedge && phi1_negedge) begin
            // End of phi0 and start of the next one at once: the hold is aborted immediately.
            data_out_en_o <= 1'b0;
            data_out_o    <= 8'h00;
            grant_o       <= '0;
            state         <= S_WAIT;
          end else if (phi1_posedge) begin
            hold_cnt <= 4'(HOLD_CYCLES);
            state    <= S_HOLD;
          end else begin
            data_out_o <= gnt_data;
          end
        end
        S_HOLD: begin
          if (phi1_negedge || hold_cnt <= 4'd1) begin
            data_out_en_o <= 1'b0;
            data_out_o    <= 8'h00;
            grant_o       <= '0;
            hold_cnt      <= '0;
            state         <= phi1_negedge ? S_WAIT : S_IDLE;
          end else begin
            hold_cnt <= hold_cnt - 4'd1;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_bus_out_arbiter.sv
// Directed bench for bus_out_arbiter: expectations are queued per step and checked
// against three instances (defaults, long hold, outputs disabled).
module tb_bus_out_arbiter;

  logic        clk_logic = 1'b0;
  logic        device_reset_n = 1'b1;
  logic        phi1_negedge = 1'b0, phi1_posedge = 1'b0;
  logic        phi_neg15 = 1'b0, phi_pos15 = 1'b0;
  logic        rw_n = 1'b1;
  logic [3:0]  req_i = 4'b0000;
  logic [31:0] data_i = 32'h0;
  logic [3:0]  irq_n_i = 4'hF;
  logic [3:0]  irq_mask_i = 4'h0;

  logic       en, irq, conf, en15, irq15, conf15, en_off, irq_off, conf_off;
  logic [7:0] data, cnt, data15, cnt15, data_off, cnt_off;
  logic [3:0] grant, grant15, grant_off;

  always #5 clk_logic = ~clk_logic;

  bus_out_arbiter dut (
    .clk_logic(clk_logic), .device_reset_n(device_reset_n),
    .phi1_negedge(phi1_negedge), .phi1_posedge(phi1_posedge), .rw_n(rw_n),
    .req_i(req_i), .data_i(data_i), .irq_n_i(irq_n_i), .irq_mask_i(irq_mask_i),
    .data_out_en_o(en), .data_out_o(data), .grant_o(grant), .irq_n_o(irq),
    .conflict_o(conf), .conflict_count_o(cnt));

  bus_out_arbiter #(.HOLD_CYCLES(15)) dut15 (
    .clk_logic(clk_logic), .device_reset_n(device_reset_n),
    .phi1_negedge(phi_neg15), .phi1_posedge(phi_pos15), .rw_n(rw_n),
    .req_i(req_i), .data_i(data_i), .irq_n_i(irq_n_i), .irq_mask_i(irq_mask_i),
    .data_out_en_o(en15), .data_out_o(data15), .grant_o(grant15), .irq_n_o(irq15),
    .conflict_o(conf15), .conflict_count_o(cnt15));

  bus_out_arbiter #(.BUS_DATA_OUT_ENABLE(0), .IRQ_OUT_ENABLE(0)) dut_off (
    .clk_logic(clk_logic), .device_reset_n(device_reset_n),
    .phi1_negedge(phi1_negedge), .phi1_posedge(phi1_posedge), .rw_n(rw_n),
    .req_i(req_i), .data_i(data_i), .irq_n_i(irq_n_i), .irq_mask_i(irq_mask_i),
    .data_out_en_o(en_off), .data_out_o(data_off), .grant_o(grant_off), .irq_n_o(irq_off),
    .conflict_o(conf_off), .conflict_count_o(cnt_off));

  typedef enum {O_EN, O_DATA, O_GRANT, O_CONF, O_CNT, O_IRQ,
                O_EN15, O_GRANT15, O_DATA15,
                O_EN_OFF, O_GRANT_OFF, O_DATA_OFF, O_IRQ_OFF} sel_t;

  typedef struct {
    string       tag;
    sel_t        sel;
    logic [31:0] val;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  function automatic logic [31:0] obs(input sel_t s);
    case (s)
      O_EN:        return {31'd0, en};
      O_DATA:      return {24'd0, data};
      O_GRANT:     return {28'd0, grant};
      O_CONF:      return {31'd0, conf};
      O_CNT:       return {24'd0, cnt};
      O_IRQ:       return {31'd0, irq};
      O_EN15:      return {31'd0, en15};
      O_GRANT15:   return {28'd0, grant15};
      O_DATA15:    return {24'd0, data15};
      O_EN_OFF:    return {31'd0, en_off};
      O_GRANT_OFF: return {28'd0, grant_off};
      O_DATA_OFF:  return {24'd0, data_off};
      default:     return {31'd0, irq_off};
    endcase
  endfunction

  task automatic exp_out(input string tag, input sel_t s, input logic [31:0] v);
    exp_t e;
    e.tag = tag;
    e.sel = s;
    e.val = v;
    sb.push_back(e);
  endtask

  task automatic exp_bus(input string tag, input logic e_en, input logic [7:0] e_data,
                         input logic [3:0] e_grant);
    exp_out({tag, "_en"}, O_EN, {31'd0, e_en});
    exp_out({tag, "_data"}, O_DATA, {24'd0, e_data});
    exp_out({tag, "_grant"}, O_GRANT, {28'd0, e_grant});
  endtask

  task automatic exp_reset(input string tag);
    exp_bus(tag, 1'b0, 8'h00, 4'b0000);
    exp_out({tag, "_conf"}, O_CONF, 32'd0);
    exp_out({tag, "_cnt"}, O_CNT, 32'd0);
    exp_out({tag, "_irq"}, O_IRQ, 32'd1);
    exp_out({tag, "_en15"}, O_EN15, 32'd0);
    exp_out({tag, "_grant15"}, O_GRANT15, 32'd0);
    exp_out({tag, "_grant_off"}, O_GRANT_OFF, 32'd0);
    exp_out({tag, "_irq_off"}, O_IRQ_OFF, 32'd1);
  endtask

  task automatic drain();
    exp_t        e;
    logic [31:0] o;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      o = obs(e.sel);
      checks++;
      assert (o === e.val) else begin
        errors++;
        $error("FAIL %s: observed 0x%0h expected 0x%0h", e.tag, o, e.val);
      end
    end
  endtask

  task automatic step();
    @(posedge clk_logic);
    #1;
    drain();
  endtask

  task automatic set_card(input int k, input logic [7:0] v);
    data_i[8*k +: 8] = v;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int exp_cnt;

    // Asynchronous reset before any clock edge
    #1 device_reset_n = 1'b0;
    #1;
    exp_reset("rst_async");
    drain();
    @(posedge clk_logic);
    @(posedge clk_logic);
    #3 device_reset_n = 1'b1;

    // Single card read with hold
    set_card(2, 8'hA5);
    req_i = 4'b0100;
    phi1_negedge = 1'b1;
    exp_bus("t1_wait", 1'b0, 8'h00, 4'b0000);
    step();
    phi1_negedge = 1'b0;
    exp_bus("t1_grant", 1'b1, 8'hA5, 4'b0100);
    exp_out("t1_conf", O_CONF, 32'd0);
    exp_out("t1_en_off", O_EN_OFF, 32'd0);
    exp_out("t1_grant_off", O_GRANT_OFF, 32'h4);
    exp_out("t1_data_off", O_DATA_OFF, 32'hA5);
    exp_out("t1_grant15", O_GRANT15, 32'd0);
    step();
    set_card(2, 8'h5A);
    exp_bus("t1_redrive", 1'b1, 8'h5A, 4'b0100);
    step();
    phi1_posedge = 1'b1;
    set_card(2, 8'h33);
    exp_bus("t1_freeze", 1'b1, 8'h5A, 4'b0100);
    step();
    phi1_posedge = 1'b0;
    req_i = 4'b0000;
    exp_bus("t1_hold", 1'b1, 8'h5A, 4'b0100);
    step();
    exp_bus("t1_release", 1'b0, 8'h00, 4'b0000);
    step();

    // Conflicts and counter saturation
    set_card(1, 8'h11);
    req_i = 4'b0110;
    phi1_negedge = 1'b1;
    exp_out("t2_wait_en", O_EN, 32'd0);
    step();
    phi1_negedge = 1'b0;
    exp_bus("t2_grant", 1'b1, 8'h11, 4'b0010);
    exp_out("t2_conf", O_CONF, 32'd1);
    exp_out("t2_cnt", O_CNT, 32'd1);
    step();
    exp_out("t2_pulse_end", O_CONF, 32'd0);
    exp_out("t2_cnt_hold", O_CNT, 32'd1);
    step();
    phi1_negedge = 1'b1;
    phi1_posedge = 1'b1;
    exp_bus("t2_both", 1'b0, 8'h00, 4'b0000);
    step();
    phi1_negedge = 1'b0;
    phi1_posedge = 1'b0;
    exp_bus("t2_regrant", 1'b1, 8'h11, 4'b0010);
    exp_out("t2_conf2", O_CONF, 32'd1);
    exp_out("t2_cnt2", O_CNT, 32'd2);
    step();
    exp_cnt = 2;
    for (int i = 0; i < 300; i++) begin
      phi1_negedge = 1'b1;
      phi1_posedge = 1'b1;
      step();
      phi1_negedge = 1'b0;
      phi1_posedge = 1'b0;
      step();
      exp_cnt = (exp_cnt < 255) ? exp_cnt + 1 : 255;
    end
    phi1_posedge = 1'b1;
    exp_out("t2_saturate", O_CNT, 32'(exp_cnt));
    exp_out("t2_sat_en", O_EN, 32'd1);
    step();
    phi1_posedge = 1'b0;
    step();
    exp_bus("t2_done", 1'b0, 8'h00, 4'b0000);
    exp_out("t2_sat_keep", O_CNT, 32'd255);
    step();

    // Write cycle never grants
    req_i = 4'b0001;
    rw_n = 1'b0;
    phi1_negedge = 1'b1;
    step();
    phi1_negedge = 1'b0;
    for (int i = 0; i < 3; i++) begin
      exp_bus("t3_write", 1'b0, 8'h00, 4'b0000);
      step();
    end
    phi1_posedge = 1'b1;
    exp_bus("t3_end", 1'b0, 8'h00, 4'b0000);
    step();
    phi1_posedge = 1'b0;
    rw_n = 1'b1;
    exp_bus("t3_idle", 1'b0, 8'h00, 4'b0000);
    step();
    exp_bus("t3_idle2", 1'b0, 8'h00, 4'b0000);
    step();

    // Early request drop
    set_card(0, 8'hC3);
    phi1_negedge = 1'b1;
    exp_bus("t4_wait", 1'b0, 8'h00, 4'b0000);
    step();
    phi1_negedge = 1'b0;
    exp_bus("t4_grant", 1'b1, 8'hC3, 4'b0001);
    step();
    req_i = 4'b0000;
    exp_out("t4_drop_en", O_EN, 32'd0);
    exp_out("t4_drop_grant", O_GRANT, 32'd0);
    step();
    req_i = 4'b0001;
    exp_out("t4_reraise_en", O_EN, 32'd0);
    exp_out("t4_reraise_grant", O_GRANT, 32'd0);
    step();
    exp_out("t4_reraise_en2", O_EN, 32'd0);
    exp_out("t4_reraise_grant2", O_GRANT, 32'd0);
    step();

    // Long hold aborted by a new bus cycle
    phi_neg15 = 1'b1;
    exp_out("t5_wait", O_EN15, 32'd0);
    step();
    phi_neg15 = 1'b0;
    exp_out("t5_grant_en", O_EN15, 32'd1);
    exp_out("t5_grant", O_GRANT15, 32'h1);
    exp_out("t5_data", O_DATA15, 32'hC3);
    exp_out("t5_main_idle", O_GRANT, 32'd0);
    step();
    phi_pos15 = 1'b1;
    exp_out("t5_hold0", O_EN15, 32'd1);
    step();
    phi_pos15 = 1'b0;
    exp_out("t5_hold1", O_EN15, 32'd1);
    step();
    exp_out("t5_hold2", O_EN15, 32'd1);
    step();
    phi_neg15 = 1'b1;
    exp_out("t5_abort_en", O_EN15, 32'd0);
    exp_out("t5_abort_grant", O_GRANT15, 32'd0);
    step();
    phi_neg15 = 1'b0;
    exp_out("t5_regrant_en", O_EN15, 32'd1);
    exp_out("t5_regrant", O_GRANT15, 32'h1);
    step();
    phi_pos15 = 1'b1;
    exp_out("t5_long0", O_EN15, 32'd1);
    step();
    phi_pos15 = 1'b0;
    for (int i = 0; i < 14; i++) begin
      exp_out("t5_long", O_EN15, 32'd1);
      step();
    end
    exp_out("t5_expire_en", O_EN15, 32'd0);
    exp_out("t5_expire_grant", O_GRANT15, 32'd0);
    step();

    // Interrupt aggregation
    irq_n_i = 4'b1011;
    irq_mask_i = 4'b0100;
    exp_out("t6_latency", O_IRQ, 32'd1);
    #1;
    drain();
    exp_out("t6_assert", O_IRQ, 32'd0);
    exp_out("t6_off", O_IRQ_OFF, 32'd1);
    step();
    irq_mask_i = 4'b1011;
    exp_out("t6_masked", O_IRQ, 32'd1);
    step();
    irq_mask_i = 4'b0100;
    exp_out("t6_reassert", O_IRQ, 32'd0);
    step();

    // Asynchronous reset in the middle of HOLD
    req_i = 4'b0100;
    set_card(2, 8'hA5);
    phi1_negedge = 1'b1;
    step();
    phi1_negedge = 1'b0;
    exp_bus("t7_grant", 1'b1, 8'hA5, 4'b0100);
    step();
    phi1_posedge = 1'b1;
    exp_out("t7_hold_en", O_EN, 32'd1);
    exp_out("t7_hold_grant_off", O_GRANT_OFF, 32'h4);
    step();
    phi1_posedge = 1'b0;
    #1 device_reset_n = 1'b0;
    #1;
    exp_reset("t7_rst");
    drain();
    exp_bus("t7_rst_clk", 1'b0, 8'h00, 4'b0000);
    step();
    #2 device_reset_n = 1'b1;
    exp_bus("t7_nofresh", 1'b0, 8'h00, 4'b0000);
    step();
    exp_bus("t7_nofresh2", 1'b0, 8'h00, 4'b0000);
    step();
    phi1_negedge = 1'b1;
    step();
    phi1_negedge = 1'b0;
    exp_bus("t7_fresh", 1'b1, 8'hA5, 4'b0100);
    step();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
